// File: rtl/note_seq_pkg.sv
// note_seq_pkg
//   Shared definitions for the note sequencer: the sequencer state
//   encoding, the default parameter values and a helper that sizes the
//   tick counter.
package note_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_TICKS_PER_NOTE = 25;
    localparam int unsigned DEF_SONG_LEN       = 32;
    localparam int unsigned DEF_ADDR_W         = 5;

    // Width of a counter that holds 0..ticks-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/tempo_divider.sv
// tempo_divider
//   Tick counter that measures out one note. Counts 0..TICKS-1 while
//   enabled and wraps to 0 after the terminal count.
//   Ports:
//     clk      - system clock, rising edge
//     reset    - synchronous active-high reset, counter to 0
//     enable   - advance the count this cycle
//     clear    - force the count to 0 (wins over enable)
//     terminal - high while the count equals TICKS-1
module tempo_divider
    import note_seq_pkg::*;
#(
    parameter int unsigned TICKS = DEF_TICKS_PER_NOTE
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam int unsigned      CNT_W = cnt_width(TICKS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign terminal = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = terminal ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
//   Steps through the note addresses of a song, holding each note for
//   TICKS_PER_NOTE clock cycles, with play/pause, restart and an end-of-song
//   state. All outputs are registered.
//   Ports:
//     clk         - system clock, rising edge
//     reset       - synchronous active-high reset, overrides everything
//     play        - play/pause level (1 = play, 0 = pause)
//     restart     - one-cycle pulse returning the song to address 0
//     note_addr   - address of the current note to the song memory
//     note_valid  - high while playing
//     note_strobe - one-cycle pulse when a new note starts
//     done        - high once the song has ended
//   Build option:
//     NOTE_SEQ_LOOP_EN - when defined, the song wraps to address 0 and keeps
//                        playing instead of stopping in DONE.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned TICKS_PER_NOTE = DEF_TICKS_PER_NOTE,
    parameter int unsigned SONG_LEN       = DEF_SONG_LEN,
    parameter int unsigned ADDR_W         = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              restart,
    output logic [ADDR_W-1:0] note_addr,
    output logic              note_valid,
    output logic              note_strobe,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              strobe_q, strobe_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic cnt_en;
    logic cnt_clr;
    logic terminal;

    tempo_divider #(
        .TICKS(TICKS_PER_NOTE)
    ) u_tempo (
        .clk      (clk),
        .reset    (reset),
        .enable   (cnt_en),
        .clear    (cnt_clr),
        .terminal (terminal)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        strobe_d = 1'b0;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;

        if (restart) begin
            addr_d  = '0;
            cnt_clr = 1'b1;
            if (play) begin
                state_d  = PLAYING;
                strobe_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (play) begin
                        state_d  = PLAYING;
                        addr_d   = '0;
                        cnt_clr  = 1'b1;
                        strobe_d = 1'b1;
                    end
                end
                PLAYING: begin
                    // Pause is checked before the tick so a pause landing on
                    // the terminal count holds the counter there; the advance
                    // then happens on the first playing cycle after resume.
                    if (!play) begin
                        state_d = PAUSED;
                    end else begin
                        cnt_en = 1'b1;
                        if (terminal) begin
                            if (addr_q == LAST_ADDR) begin
`ifdef NOTE_SEQ_LOOP_EN
                                addr_d   = '0;
                                strobe_d = 1'b1;
`else
                                state_d  = DONE;
`endif
                            end else begin
                                addr_d   = addr_q + ADDR_W'(1);
                                strobe_d = 1'b1;
                            end
                        end
                    end
                end
                PAUSED: begin
                    // Resume does not tick; counting restarts next cycle from
                    // the frozen value, and no strobe is issued.
                    if (play) begin
                        state_d = PLAYING;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        valid_d = (state_d == PLAYING);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            strobe_q <= strobe_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign note_addr   = addr_q;
    assign note_valid  = valid_q;
    assign note_strobe = strobe_q;
    assign done        = done_q;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_NOTE, default 25: clk cycles per note, legal range 2..65535.
REQ-002 SHALL have parameter SONG_LEN, default 32: number of note addresses, legal range 2..2**ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 5: note address width.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port play  input  1  play/pause level from the play/pause FSM output: 1 = play, 0 = pause.
REQ-007 SHALL have port restart  input  1  single-cycle pulse that returns the song to address 0.
REQ-008 SHALL have port note_addr  output  ADDR_W  address of the current note, to the song memory.
REQ-009 SHALL have port note_valid  output  1  high while state is PLAYING.
REQ-010 SHALL have port note_strobe  output  1  one-cycle pulse when a new note starts.
REQ-011 SHALL have port done  output  1  high while state is DONE.

Function
REQ-012 SHALL implement states IDLE, PLAYING, PAUSED and DONE; all outputs are registered.
REQ-013 In IDLE with play=1, the next state SHALL be PLAYING, with note_addr=0, tick counter=0 and note_strobe=1 for that cycle.
REQ-014 In PLAYING, the tick counter SHALL increment each cycle; at TICKS_PER_NOTE-1 it wraps to 0, note_addr increments and note_strobe=1 for one cycle.
REQ-015 In PLAYING with play=0, the next state SHALL be PAUSED, with the tick counter and note_addr frozen and note_valid=0.
REQ-016 In PAUSED with play=1, the next state SHALL be PLAYING, resuming mid-note from the frozen count; no note_strobe on resume.
REQ-017 End of song: when note_addr=SONG_LEN-1 and the counter reaches its terminal count, the behaviour SHALL be as defined in REQ-024/025.
REQ-018 DONE SHALL be exited only by restart or reset; play has no effect in DONE.
REQ-019 restart SHALL have priority over the tick and over play: note_addr=0, counter=0; next state is PLAYING with note_strobe=1 if play=1, else IDLE.
REQ-020 If play falls on the same cycle as the terminal count, the pause SHALL win: no advance, counter held at TICKS_PER_NOTE-1, and the advance happens on the first cycle after resume.
REQ-021 note_addr SHALL never exceed SONG_LEN-1; the counter width is $clog2(TICKS_PER_NOTE).

Reset
REQ-022 While reset=1 at a clk edge, the block SHALL enter IDLE with note_addr=0, counter=0, note_valid=0, note_strobe=0 and done=0.
REQ-023 Reset SHALL override restart, play and any in-progress note, including in PAUSED and DONE.

Configuration
REQ-024 With macro NOTE_SEQ_LOOP_EN defined, end of song SHALL wrap note_addr to 0 with note_strobe=1, stay in PLAYING, and keep done at 0.
REQ-025 Without NOTE_SEQ_LOOP_EN, end of song SHALL enter DONE with note_addr held at SONG_LEN-1, note_valid=0, note_strobe=0 and done=1.

Structure
REQ-026 Package note_seq_pkg SHALL hold the state encoding typedef (IDLE, PLAYING, PAUSED, DONE) and the default parameter constants.
REQ-027 The tick counter SHALL be a sub-module tempo_divider with inputs clk, reset, enable and clear and output terminal, instantiated once.

Verification (TICKS_PER_NOTE=4, SONG_LEN=4)
REQ-028 Reset, then play=1 held -> note_strobe at cycle 1 with addr 0; further strobes every 4 cycles with addr 1, 2, 3.
REQ-029 play=0 after 2 ticks of addr 1 for 10 cycles, then play=1 -> addr stays 1; the next strobe (addr 2) comes 2 cycles after resume.
REQ-030 Play through addr 3 without the macro -> done=1, note_valid=0, addr=3; toggling play leaves all three unchanged.
REQ-031 Same run with NOTE_SEQ_LOOP_EN -> strobe with addr 0 at the 16th cycle after the first strobe, done=0.
REQ-032 restart pulse at addr 2 with play=1 -> next cycle addr=0 with note_strobe=1; with play=0 -> state IDLE, addr=0.
REQ-033 reset=1 during PAUSED at addr 2 -> next cycle IDLE, all outputs 0; play=1 then restarts from addr 0.
